mc_unit_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared multi-cycle unit. The unit is a fixed-latency start/done block, such as the 3-bit done counter.
- Accepts level requests from NREQ clients and grants one at a time. Issues a one-cycle start pulse to the unit, waits for its level done, then acks the granted client.
- A watchdog aborts the operation if done never arrives.
- Sits between the client FSMs and the shared unit; it is the only driver of the unit's start.

---
 rtl/mc_unit_arbiter_pkg.sv | 25 ++
 rtl/mc_unit_arbiter_op_timer.sv | 21 ++
 rtl/mc_unit_arbiter.sv | 75 +++++++
 tb/tb_mc_unit_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mc_unit_arbiter_pkg.sv
// mc_unit_arbiter_pkg: state encoding, default sizing and the round-robin pick shared by the arbiter.
package mc_unit_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;
  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 16;
  localparam int TW_DEF   = 5;
  // Walk from farthest to nearest so the closest set bit after ptr wins.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [7:0] g;
    int idx;
    g = '0;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[2:0]]) g = 8'b1 << idx[2:0];
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/mc_unit_arbiter_op_timer.sv
// mc_unit_arbiter_op_timer: watchdog down-counter; expired flags the last permitted WAIT cycle.
module mc_unit_arbiter_op_timer
  import mc_unit_arbiter_pkg::*;
#(
  parameter int TMO = TMO_DEF,
  parameter int TW  = TW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= TW'(TMO);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - TW'(1);
  end
  assign o_expired = (r_cnt == TW'(1));
endmodule

// File: rtl/mc_unit_arbiter.sv
// mc_unit_arbiter: round-robin owner selection and start/done sequencing of one shared multi-cycle unit
// with a watchdog abort.
module mc_unit_arbiter
  import mc_unit_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = TMO_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] ack,
  output logic            err,
  output logic            busy,
  output logic            unit_start,
  input  logic            unit_done
);
  localparam int PW = $clog2(NREQ);
  state_t          r_state, w_next;
  logic [NREQ-1:0] r_grant, r_ack, w_pick;
  logic            r_err, w_expired, w_fin;
  logic [PW-1:0]   r_ptr, w_owner;

  mc_unit_arbiter_op_timer #(.TMO(TMO), .TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_state == START),
    .i_dec    (r_state == WAIT),
    .o_expired(w_expired)
  );

  assign w_pick = NREQ'(rr_pick(8'(req), 3'(r_ptr), NREQ));
  // Done has priority over a coincident timeout; done outside WAIT never reaches here.
  assign w_fin  = (r_state == WAIT) && (unit_done || w_expired);

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_grant[i]) w_owner = PW'(i);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |req ? START : IDLE;
      START:   w_next = WAIT;
      WAIT:    w_next = w_fin ? RELEASE : WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_ptr   <= PW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      r_grant <= (r_state == IDLE) ? w_pick : w_fin ? '0 : r_grant;
      r_ack   <= (w_fin && unit_done) ? r_grant : '0;
      r_err   <= w_fin && !unit_done;
      if (w_fin) r_ptr <= w_owner;
    end
  end

  assign grant      = r_grant;
  assign ack        = r_ack;
  assign err        = r_err;
  assign busy       = (r_state == START) || (r_state == WAIT);
  assign unit_start = (r_state == START);
endmodule

// File: tb/tb_mc_unit_arbiter.sv
// tb_mc_unit_arbiter: directed checks of arbitration order, start/done timing, watchdog and reset
// against a latency-8 sticky-done unit model.
module tb_mc_unit_arbiter;
  localparam int NREQ = 4;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant, ack;
  logic            err, busy, unit_start;
  logic            unit_done = 1'b0;
  logic [3:0]      ucnt = '0;
  bit              unit_en = 1'b1;
  int              cyc = 0;
  int              pass_n = 0;
  int              total = 0;
  int              g1, g2, c0;

  always #5 clk = ~clk;

  mc_unit_arbiter #(.NREQ(NREQ), .TMO(16), .TW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .unit_start(unit_start),
    .unit_done (unit_done)
  );

  // Unit: done clears on the start edge and rises 8 edges later, then stays high until the next start.
  always @(posedge clk) begin
    if (unit_start) begin
      ucnt      <= 4'd8;
      unit_done <= 1'b0;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 4'd1;
      if (ucnt == 4'd1 && unit_en) unit_done <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_g, output int g);
    int n = 0;
    while (grant == 0 && n < 40) begin
      tick();
      n++;
    end
    g = cyc;
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    chk({tag, "_start"}, 32'(unit_start), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic wait_end(input string tag, input logic [3:0] exp_ack, input bit exp_err,
                          input int g, input int lat);
    int n = 0;
    while (ack == 0 && err == 0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(cyc - g), 32'(lat));
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_gclr"}, 32'(grant), 0);
  endtask

  task automatic op(input string tag, input logic [3:0] exp_g, input bit exp_err, input int lat,
                    output int g);
    wait_grant(tag, exp_g, g);
    wait_end(tag, exp_err ? 4'b0000 : exp_g, exp_err, g, lat);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(unit_start), 0);
    tick();
    rst = 1'b0;
    req = 4'b0001;
    c0 = cyc;
    op("t1", 4'b0001, 1'b0, 10, g1);
    chk("t1_gcyc", 32'(g1 - c0), 1);
    req = 4'b0000;
    tick();
    chk("t1_ackpulse", 32'(ack), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    reset_pulse();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      op("t2", 4'b0001 << (k % 4), 1'b0, 10, g2);
      if (k > 0) chk("t2_period", 32'(g2 - g1), 12);
      g1 = g2;
    end
    req = 4'b0000;
    tick();

    unit_en = 1'b0;
    req = 4'b0100;
    op("t3", 4'b0100, 1'b1, 17, g1);
    req = 4'b0000;
    tick();
    chk("t3_errpulse", 32'(err), 0);
    chk("t3_noack", 32'(ack), 0);
    unit_en = 1'b1;
    req = 4'b0001;
    op("t3b", 4'b0001, 1'b0, 10, g1);
    req = 4'b0000;
    tick();

    tick();
    chk("t4_idle_ack", 32'(ack), 0);
    chk("t4_idle_busy", 32'(busy), 0);
    req = 4'b0010;
    op("t4", 4'b0010, 1'b0, 10, g1);
    req = 4'b0000;
    tick();

    req = 4'b0001;
    wait_grant("t5a", 4'b0001, g1);
    tick();
    tick();
    chk("t5_inwait", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_start", 32'(unit_start), 0);
    req = 4'b1000;
    tick();
    rst = 1'b0;
    op("t5", 4'b1000, 1'b0, 10, g1);
    req = 4'b0000;
    tick();
    reset_pulse();
    req = 4'b1010;
    op("t5b", 4'b0010, 1'b0, 10, g1);
    req = 4'b0000;
    tick();

    req = 4'b0010;
    wait_grant("t6a", 4'b0010, g1);
    tick();
    tick();
    req = 4'b0100;
    wait_end("t6a", 4'b0010, 1'b0, g1, 10);
    wait_grant("t6b", 4'b0100, g2);
    chk("t6_period", 32'(g2 - g1), 12);
    wait_end("t6b", 4'b0100, 1'b0, g2, 10);
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
